// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants and types for the VGA text-overlay path.
// Character buffer items:
//   CHAR_BUF_DEPTH   number of cells in the 16x16 character buffer
//   CHAR_BLANK       blank (space) character code used to clear the buffer
//   char_buf_state_t controller state: CLEAR sweeps the buffer, IDLE serves writers
package vga_pkg;

  localparam int         CHAR_BUF_DEPTH = 256;
  localparam logic [7:0] CHAR_BLANK     = 8'h20;

  typedef enum logic {
    CLEAR,
    IDLE
  } char_buf_state_t;

endpackage

// File: rtl/char_buf_ram.sv
// char_buf_ram
// 256 x 8 character storage with one write port and one synchronous read port.
// The array itself has no reset so it maps onto distributed or block RAM;
// only the read data register is reset.
// Ports:
//   clk65MHz  pixel clock
//   rst_n     asynchronous active-low reset (read register only)
//   we        write enable
//   waddr     write address {row, col}
//   wdata     write data
//   raddr     read address {row, col}
//   rdata     registered read data, 1-cycle latency
module char_buf_ram
  import vga_pkg::*;
(
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [CHAR_BUF_DEPTH];

  // Write port; no reset so the array stays RAM-inferable.
  always_ff @(posedge clk65MHz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; a same-cycle write to raddr is not visible until the next read,
  // so the old contents are returned.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl
// Owns the 16x16 character buffer feeding the text overlay. Two writers share
// the single write port through a round-robin arbiter; a clear sequencer fills
// every cell with CLEAR_CHAR after reset and on request.
// Ports:
//   clk65MHz   pixel clock
//   rst_n      asynchronous active-low reset
//   clear_req  request a full-buffer clear (honoured in IDLE only)
//   busy       high while the clear sequence runs
//   req        per-client write request, bit i = client i
//   addr0/1    per-client target cell {row[7:4], col[3:0]}
//   data0/1    per-client character code
//   gnt        one-hot write accept; the write happens at the edge where it is high
//   char_xy    read address from the drawing stage
//   char_code  registered buffer contents at char_xy
module char_buf_ctrl
  import vga_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = CHAR_BLANK
) (
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic       clear_req,
  output logic       busy,
  input  logic [1:0] req,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  input  logic [7:0] char_xy,
  output logic [7:0] char_code
);

  char_buf_state_t state;
  logic [7:0]      cnt;
  logic            last;

  logic            we;
  logic [7:0]      waddr;
  logic [7:0]      wdata;

  // Arbiter: clear (running or just requested) blocks all grants. On a tie the
  // client that was not granted most recently wins. Reset holds the state in
  // CLEAR, which keeps gnt low while rst_n is asserted.
  always_comb begin
    gnt = 2'b00;
    if (state == IDLE && !clear_req) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Write port mux: the clear sweep owns the port while in CLEAR, otherwise
  // the granted client does.
  always_comb begin
    we    = 1'b0;
    waddr = 8'h00;
    wdata = 8'h00;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = cnt;
      wdata = CLEAR_CHAR;
    end else if (gnt[0]) begin
      we    = 1'b1;
      waddr = addr0;
      wdata = data0;
    end else if (gnt[1]) begin
      we    = 1'b1;
      waddr = addr1;
      wdata = data1;
    end
  end

  // Controller FSM with the clear counter, round-robin pointer and busy flag.
  // The reset state is CLEAR with cnt = 0, so every reset gives a full clear.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= 8'h00;
      last  <= 1'b1;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) begin
            state <= IDLE;
            cnt   <= 8'h00;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= 8'h00;
            busy  <= 1'b1;
          end else if (gnt[0]) begin
            last <= 1'b0;
          end else if (gnt[1]) begin
            last <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= 8'h00;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  char_buf_ram u_ram (
    .clk65MHz (clk65MHz),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (char_xy),
    .rdata    (char_code)
  );

endmodule
